// File: rtl/w5500_spi_arbiter_pkg.sv
// w5500_spi_pkg: shared states, constants and header-byte selection for the W5500 SPI frame arbiter
package w5500_spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, HOLD, GAP} state_t;
  localparam int HDR_BYTES = 3;
  localparam int RWB_BIT = 2;
  localparam int ADDR_W = 16;
  localparam int LEN_W = 12;
  localparam int IDX_W = LEN_W + 1;
  function automatic logic [7:0] tx_byte(input logic [IDX_W-1:0] idx, input logic [ADDR_W-1:0] addr,
                                         input logic [7:0] ctrl, input logic [7:0] wd);
    return idx == '0 ? addr[15:8] : idx == IDX_W'(1) ? addr[7:0] : idx == IDX_W'(2) ? ctrl :
           ctrl[RWB_BIT] ? wd : 8'h00;
  endfunction
endpackage

// File: rtl/w5500_spi_arbiter_if.sv
// w5500_spi_arbiter_if: requester bundle plus byte-wide SPI master handshake
interface w5500_spi_arbiter_if #(parameter int NREQ = 2);
  import w5500_spi_pkg::*;
  logic [NREQ-1:0] req, gnt, wdata_rd, rvalid, frame_done;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*8-1:0] ctrl, wdata;
  logic [NREQ*LEN_W-1:0] len;
  logic [7:0] rdata, spi_tx, spi_rx;
  logic busy, spi_start, spi_done, spi_csn;
  modport slave (input req, addr, ctrl, len, wdata, spi_done, spi_rx,
                 output gnt, wdata_rd, rdata, rvalid, frame_done, busy, spi_start, spi_tx, spi_csn);
  modport master (output req, addr, ctrl, len, wdata, spi_done, spi_rx,
                  input gnt, wdata_rd, rdata, rvalid, frame_done, busy, spi_start, spi_tx, spi_csn);
endinterface

// File: rtl/w5500_spi_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant from a pointer that moves past the last winner on i_adv
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_adv,
  input  logic [IW-1:0]   i_idx,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  logic [IW-1:0] r_ptr, w_j;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= '0;
    else if (i_adv) r_ptr <= int'(i_idx) == NREQ - 1 ? '0 : i_idx + 1'b1;
  // scan from farthest to nearest so the request closest to the pointer wins
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = IW'((int'(r_ptr) + k) % NREQ);
      if (i_req[w_j]) begin
        o_gnt = '0;
        o_gnt[w_j] = 1'b1;
        o_idx = w_j;
      end
    end
  end
  assign o_any = |i_req;
endmodule

// File: rtl/w5500_spi_arbiter.sv
// w5500_spi_arbiter: grants one requester a whole W5500 frame (3-byte header + data) on a shared SPI byte master
module w5500_spi_arbiter #(
  parameter int NREQ = 2,
  parameter int CS_SETUP = 1,
  parameter int CS_GAP = 2
) (
  input logic clk,
  input logic rst,
  w5500_spi_arbiter_if.slave bus
);
  import w5500_spi_pkg::*;
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t r_state;
  logic [NREQ-1:0] r_gnt, r_wdata_rd, r_rvalid, r_frame_done, w_gnt;
  logic [IW-1:0] r_gidx, w_gidx;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0] r_ctrl, r_tx, r_rdata, w_wdata, w_tx;
  logic [LEN_W-1:0] r_len, w_len;
  logic [IDX_W-1:0] r_idx, w_idx_nx, w_sel;
  logic [15:0] r_cnt;
  logic r_csn, r_start, r_busy, w_any, w_adv, w_last, w_wr, w_wd_rd;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .clk(clk), .rst(rst), .i_req(bus.req), .i_adv(w_adv), .i_idx(r_gidx),
    .o_gnt(w_gnt), .o_idx(w_gidx), .o_any(w_any)
  );
  assign w_len = bus.len[int'(w_gidx)*LEN_W +: LEN_W];
  assign w_wdata = bus.wdata[int'(r_gidx)*8 +: 8];
  assign w_wr = r_ctrl[RWB_BIT];
  assign w_idx_nx = r_idx + 1'b1;
  assign w_last = w_idx_nx == {1'b0, r_len} + IDX_W'(HDR_BYTES);
  assign w_adv = r_state == WAIT && bus.spi_done && w_last;
  // byte index of the transfer about to start: 0 from SETUP, idx+1 from WAIT
  assign w_sel = r_state == WAIT ? w_idx_nx : '0;
  assign w_tx = tx_byte(w_sel, r_addr, r_ctrl, w_wdata);
  assign w_wd_rd = w_wr && w_sel >= IDX_W'(HDR_BYTES);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_gidx <= '0;
      r_addr <= '0;
      r_ctrl <= '0;
      r_len <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_csn <= 1'b1;
      r_start <= 1'b0;
      r_tx <= '0;
      r_wdata_rd <= '0;
      r_rdata <= '0;
      r_rvalid <= '0;
      r_frame_done <= '0;
      r_busy <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_wdata_rd <= '0;
      r_rvalid <= '0;
      r_frame_done <= '0;
      case (r_state)
        IDLE: if (w_any) begin
          r_gnt <= w_gnt;
          r_gidx <= w_gidx;
          r_addr <= bus.addr[int'(w_gidx)*ADDR_W +: ADDR_W];
          r_ctrl <= bus.ctrl[int'(w_gidx)*8 +: 8];
          r_len <= w_len == '0 ? LEN_W'(1) : w_len;
          r_csn <= 1'b0;
          r_idx <= '0;
          r_cnt <= '0;
          r_busy <= 1'b1;
          r_state <= SETUP;
        end
        SETUP: if (int'(r_cnt) + 1 >= CS_SETUP) begin
          r_state <= SEND;
          r_start <= 1'b1;
          r_tx <= w_tx;
          r_wdata_rd <= w_wd_rd ? r_gnt : '0;
        end else r_cnt <= r_cnt + 1'b1;
        SEND: r_state <= WAIT;
        WAIT: if (bus.spi_done) begin
          r_idx <= w_idx_nx;
          if (!w_wr && r_idx >= IDX_W'(HDR_BYTES)) begin
            r_rdata <= bus.spi_rx;
            r_rvalid <= r_gnt;
          end
          if (w_last) begin
            r_state <= HOLD;
            r_csn <= 1'b1;
            r_frame_done <= r_gnt;
            r_gnt <= '0;
          end else begin
            r_state <= SEND;
            r_start <= 1'b1;
            r_tx <= w_tx;
            r_wdata_rd <= w_wd_rd ? r_gnt : '0;
          end
        end
        HOLD: begin
          r_state <= GAP;
          r_cnt <= '0;
        end
        GAP: if (int'(r_cnt) + 1 >= CS_GAP) begin
          r_state <= IDLE;
          r_busy <= 1'b0;
        end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.gnt = r_gnt;
  assign bus.wdata_rd = r_wdata_rd;
  assign bus.rdata = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.frame_done = r_frame_done;
  assign bus.busy = r_busy;
  assign bus.spi_start = r_start;
  assign bus.spi_tx = r_tx;
  assign bus.spi_csn = r_csn;
endmodule
